// File: rtl/clk_en_scheduler.sv
// clk_en_scheduler: multi-channel clock-enable scheduler, single clock domain.
// Each channel emits a one-cycle tick every <divisor> cycles plus a square-wave
// level. Divisor changes to a running channel are held as pending and take
// effect on that channel's next wrap, so no period is ever cut short.
//
// Ports:
//   clk_i, rst_i        system clock, synchronous active-high reset
//   run_i               global run; low freezes every channel counter
//   sync_i              phase-align all active channels (cnt <= 0)
//   cfg_valid_i/ready_o config handshake; cfg_ch_i selects the channel,
//   cfg_ch_i, cfg_div_i cfg_div_i is the new divisor (0 = stop)
//   cfg_err_o           one-cycle pulse after an accepted out-of-range request
//   busy_o              per channel: divisor change pending
//   tick_o              per channel: registered enable strobe
//   lvl_o               per channel: square-wave level

// Per-channel divider. ld_i is a qualified transfer aimed at this channel.
module clk_en_ch #(
    parameter int DIV_W   = 24,
    parameter int RST_DIV = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    input  logic             sync_i,
    input  logic             ld_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             tick_o,
    output logic             lvl_o,
    output logic             busy_o
);
    logic [DIV_W-1:0] act_q, act_d, pend_q, pend_d, cnt_q, cnt_d;
    logic             pnd_q, pnd_d, tick_q, tick_d;
    logic             wrap;
    logic [DIV_W:0]   half;

    always_comb begin
        act_d  = act_q;
        pend_d = pend_q;
        cnt_d  = cnt_q;
        pnd_d  = pnd_q;
        tick_d = 1'b0;
        wrap   = (act_q != '0) && run_i && (cnt_q == act_q - DIV_W'(1));
        if (sync_i) begin
            // Sync wins over wrap and ignores run_i; idle channels untouched.
            if (act_q != '0) begin
                cnt_d = '0;
                if (pnd_q) begin
                    act_d = pend_q;
                    pnd_d = 1'b0;
                end
            end
        end else begin
            if (act_q != '0 && run_i) begin
                if (wrap) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    if (pnd_q) begin
                        act_d = pend_q;
                        pnd_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            // A load landing on a wrap edge is only possible with pnd_q=0
            // (ready blocks it otherwise), so it queues for the next wrap.
            if (ld_i) begin
                if (act_q == '0) begin
                    act_d = div_i;
                    cnt_d = '0;
                end else begin
                    pend_d = div_i;
                    pnd_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            act_q  <= DIV_W'(RST_DIV);
            pend_q <= '0;
            cnt_q  <= '0;
            pnd_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            act_q  <= act_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            pnd_q  <= pnd_d;
            tick_q <= tick_d;
        end
    end

    // High for the first ceil(act/2) counts of each period.
    assign half   = ({1'b0, act_q} + (DIV_W+1)'(1)) >> 1;
    assign lvl_o  = (act_q != '0) && ({1'b0, cnt_q} < half);
    assign tick_o = tick_q;
    assign busy_o = pnd_q;
endmodule

module clk_en_scheduler #(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 24,
    parameter int RST_DIV0 = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              sync_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [2:0]        cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic              cfg_err_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] lvl_o
);
    logic xfer, busy_sel, err_q, err_d;

    // Ready stalls only on sync or on a busy in-range target; never on valid.
    always_comb begin
        busy_sel = 1'b0;
        for (int i = 0; i < NUM_CH; i++)
            if (cfg_ch_i == 3'(i) && busy_o[i]) busy_sel = 1'b1;
        cfg_ready_o = !sync_i && !busy_sel;
    end

    assign xfer  = cfg_valid_i && cfg_ready_o;
    assign err_d = xfer && ({1'b0, cfg_ch_i} >= 4'(NUM_CH));

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= err_d;
    end
    assign cfg_err_o = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ld;
        assign ld = xfer && (cfg_ch_i == 3'(g));
        clk_en_ch #(
            .DIV_W  (DIV_W),
            .RST_DIV((g == 0) ? RST_DIV0 : 0)
        ) u_ch (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .run_i  (run_i),
            .sync_i (sync_i),
            .ld_i   (ld),
            .div_i  (cfg_div_i),
            .tick_o (tick_o[g]),
            .lvl_o  (lvl_o[g]),
            .busy_o (busy_o[g])
        );
    end
endmodule

// File: tb/tb_clk_en_scheduler.sv
module tb_clk_en_scheduler;
    logic        clk = 1'b0;
    logic        rst, run, sync, cfg_valid;
    logic [2:0]  cfg_ch;
    logic [23:0] cfg_div;
    logic        cfg_ready, cfg_err;
    logic [3:0]  busy, tick, lvl;

    int vec = 0, errs = 0, cyc = 0;
    int expq[4][$];          // expected tick cycles per channel
    logic [3:0] trk = 4'b0;  // channels whose ticks are scored
    int mon_want;

    clk_en_scheduler #(.NUM_CH(4), .DIV_W(24), .RST_DIV0(4)) dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .sync_i(sync),
        .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready), .cfg_ch_i(cfg_ch),
        .cfg_div_i(cfg_div), .cfg_err_o(cfg_err), .busy_o(busy),
        .tick_o(tick), .lvl_o(lvl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick scoreboard: every observed tick on a tracked channel must match
    // the head of that channel's expected queue.
    always @(negedge clk) begin
        for (int c = 0; c < 4; c++) begin
            if (trk[c] && tick[c] === 1'b1) begin
                vec++;
                mon_want = -1;
                if (expq[c].size() != 0) mon_want = expq[c].pop_front();
                assert (cyc === mon_want) else begin
                    errs++;
                    $error("FAIL tick%0d: got tick at cyc %0d want %0d", c, cyc, mon_want);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Returns transfer edge number and number of stalled cycles.
    task automatic cfg(input logic [2:0] ch, input logic [23:0] div,
                       output int e, output int n);
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = div;
        #1;
        n = 0;
        while (!cfg_ready && n < 100) begin step(); n++; end
        chk("cfg_timeout", 32'(n < 100), 1);
        e = cyc + 1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic drain(input int c);
        chk($sformatf("q%0d_empty", c), expq[c].size(), 0);
        trk[c] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r, e, e2, n, c0, s, r2;
        logic [4:0] lp;
        rst = 1; run = 1; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_div = 0;
        repeat (3) @(negedge clk);
        #1;
        // ---- reset state and default ch0 (div 4)
        rst = 0; r = cyc;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(cfg_err), 0);
        chk("rst_ready", 32'(cfg_ready), 1);
        trk = 4'b1111;
        expq[0].push_back(r + 4); expq[0].push_back(r + 8); expq[0].push_back(r + 12);
        lp = 5'b10011;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lvl0_%0d", k), 32'(lvl[0]), 32'(lp[k]));
            if (k < 4) step();
        end
        chk("lvl_idle", 32'(lvl[3:1]), 0);
        while (cyc < r + 13) step();
        drain(0);

        // ---- ch1 load 3 while idle, then retarget to 1 mid-period
        cfg(3'd1, 24'd3, e, n);
        for (int k = 3; k <= 8; k++) expq[1].push_back(e + k);
        step();
        cfg(3'd1, 24'd1, e2, n);
        chk("b_xfer", e2, e + 2);
        chk("b_busy_set", 32'(busy[1]), 1);
        step();
        chk("b_busy_clr", 32'(busy[1]), 0);
        chk("b_lvl_div1", 32'(lvl[1]), 1);
        while (cyc < e + 8) step();
        // stop request lands on a wrap edge: one extra period, then stop
        c0 = cyc;
        expq[1].push_back(c0 + 1); expq[1].push_back(c0 + 2);
        cfg(3'd1, 24'd0, e2, n);
        chk("b_stop_xfer", e2, c0 + 1);
        chk("b_stop_busy", 32'(busy[1]), 1);
        step(); step(); step();
        chk("b_stop_lvl", 32'(lvl[1]), 0);
        drain(1);

        // ---- stop ch0 mid-period; second write stalls until the wrap
        while (((cyc + 1 - r) % 4) != 2) step();
        c0 = cyc;
        trk[0] = 1'b1;
        expq[0].push_back(c0 + 3);
        cfg(3'd0, 24'd0, e, n);
        chk("c_xfer", e, c0 + 1);
        cfg(3'd0, 24'd0, e2, n);
        chk("c_stall", n, 2);
        chk("c_xfer2", e2, c0 + 4);
        repeat (6) step();
        chk("c_lvl0", 32'(lvl[0]), 0);
        chk("c_busy0", 32'(busy[0]), 0);
        drain(0);

        // ---- ch2 div 5, ch3 div 7, then sync
        trk[2] = 1'b0; trk[3] = 1'b0;
        cfg(3'd2, 24'd5, e, n);
        cfg(3'd3, 24'd7, e, n);
        repeat (3) step();
        s = cyc;
        sync = 1'b1;
        #1;
        chk("d_ready_sync", 32'(cfg_ready), 0);
        trk[2] = 1'b1; trk[3] = 1'b1;
        expq[2].push_back(s + 6); expq[2].push_back(s + 11);
        expq[3].push_back(s + 8); expq[3].push_back(s + 15);
        step();
        sync = 1'b0;
        while (cyc < s + 15) step();
        drain(2); drain(3);

        // ---- ch1 div 6 with a 10-cycle freeze at cnt=2
        cfg(3'd1, 24'd6, e, n);
        trk[1] = 1'b1;
        expq[1].push_back(e + 16); expq[1].push_back(e + 22);
        while (cyc < e + 2) step();
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("e_lvl_frz%0d", k), 32'(lvl[1]), 1);
            step();
        end
        run = 1'b1;
        while (cyc < e + 22) step();
        drain(1);

        // ---- out-of-range channel
        cfg(3'd6, 24'd9, e, n);
        chk("f_err_ready", n, 0);
        chk("f_err_pulse", 32'(cfg_err), 1);
        chk("f_err_busy", 32'(busy), 0);
        chk("f_err_ch0", 32'({tick[0], lvl[0]}), 0);
        step();
        chk("f_err_clr", 32'(cfg_err), 0);

        // ---- reset with a pending change
        cfg(3'd1, 24'd2, e, n);
        chk("g_busy_pend", 32'(busy[1]), 1);
        rst = 1'b1;
        step(); step();
        chk("g_busy_rst", 32'(busy), 0);
        rst = 1'b0; r2 = cyc;
        chk("g_lvl_rst", 32'(lvl), 32'h1);
        chk("g_tick_rst", 32'(tick), 0);
        trk = 4'b1111;
        expq[0].push_back(r2 + 4); expq[0].push_back(r2 + 8);
        while (cyc < r2 + 9) step();
        for (int c = 0; c < 4; c++) drain(c);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
